// File: rtl/alu_sequencer.sv
// Instruction sequencer that steps an external ALU through SETUP/FIRE/CAPTURE and issues stores.
// Optional feature macro: ALU_SEQ_CARRY_EN (builds the carry/extend flag logic for e_flag).
module alu_sequencer #(
    parameter int unsigned STORE_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_operand,
    output logic [7:0] alu_ac,
    output logic [7:0] alu_dr,
    output logic [2:0] alu_mode,
    output logic       alu_activate,
    input  logic [7:0] alu_result,
    output logic       mem_wr_valid,
    output logic [7:0] mem_wr_data,
    input  logic       mem_wr_ready,
    output logic [7:0] ac_out,
    output logic       e_flag,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_FIRE    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_STORE   = 3'd4
    } state_e;

    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SHL     = 3'b001;
    localparam logic [2:0] OP_STORE   = 3'b101;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;
    // Counter value of the last STORE cycle that may still wait for mem_wr_ready.
    localparam logic [7:0] TIMEOUT_LAST = 8'(STORE_TIMEOUT - 32'd1);

    state_e     state_q;
    logic [7:0] ac_q;
    logic [7:0] alu_ac_q;
    logic [7:0] alu_dr_q;
    logic [2:0] alu_mode_q;
    logic       act_q;
    logic       wr_valid_q;
    logic [7:0] wr_data_q;
    logic [7:0] cnt_q;
    logic       done_q;
    logic       err_q;
    logic       e_q;

    // Main sequencer: state, accumulator, ALU buses, store handshake and completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ac_q       <= 8'h00;
            alu_ac_q   <= 8'h00;
            alu_dr_q   <= 8'h00;
            alu_mode_q <= 3'b000;
            act_q      <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_data_q  <= 8'h00;
            cnt_q      <= 8'h00;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_STORE: begin
                                state_q    <= ST_STORE;
                                wr_valid_q <= 1'b1;
                                wr_data_q  <= ac_q;
                                cnt_q      <= 8'h00;
                            end
                            OP_ILLEGAL: begin
                                done_q <= 1'b1;
                                err_q  <= 1'b1;
                            end
                            default: begin
                                state_q    <= ST_SETUP;
                                alu_ac_q   <= ac_q;
                                alu_dr_q   <= cmd_operand;
                                alu_mode_q <= cmd_op;
                            end
                        endcase
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    state_q <= ST_FIRE;
                    act_q   <= 1'b1;
                end
                ST_FIRE: begin
                    state_q <= ST_CAPTURE;
                    act_q   <= 1'b0;
                end
                ST_CAPTURE: begin
                    ac_q    <= alu_result;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                ST_STORE: begin
                    // A ready arriving in the final wait cycle wins over the timeout.
                    if (mem_wr_ready) begin
                        wr_valid_q <= 1'b0;
                        cnt_q      <= 8'h00;
                        done_q     <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        wr_valid_q <= 1'b0;
                        cnt_q      <= 8'h00;
                        done_q     <= 1'b1;
                        err_q      <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    act_q      <= 1'b0;
                    wr_valid_q <= 1'b0;
                    cnt_q      <= 8'h00;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_CARRY_EN
    logic e_d;

    function automatic logic add_carry(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8];
    endfunction

    // Next carry/extend value, taken from the operands held on the ALU buses.
    always_comb begin
        e_d = e_q;
        case (alu_mode_q)
            OP_ADD:  e_d = add_carry(alu_ac_q, alu_dr_q);
            OP_SHL:  e_d = alu_dr_q[7];
            default: e_d = e_q;
        endcase
    end

    // Carry/extend flag updates only as the result is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q <= 1'b0;
        end else if (state_q == ST_CAPTURE) begin
            e_q <= e_d;
        end else begin
            e_q <= e_q;
        end
    end
`else
    assign e_q = 1'b0;
`endif

    assign cmd_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign alu_ac       = alu_ac_q;
    assign alu_dr       = alu_dr_q;
    assign alu_mode     = alu_mode_q;
    assign alu_activate = act_q;
    assign mem_wr_valid = wr_valid_q;
    assign mem_wr_data  = wr_data_q;
    assign ac_out       = ac_q;
    assign e_flag       = e_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter STORE_TIMEOUT, default 15, meaning the maximum number of cycles to wait for mem_wr_ready in STORE (legal range 1..255).
REQ-002 clk  input  1  the single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  an instruction is offered.
REQ-005 cmd_ready  output  1  the block accepts an instruction this cycle.
REQ-006 cmd_op  input  3  operation: 000 add, 001 shl, 010 xnor, 011 shr, 100 load, 101 store, 110 negate, 111 illegal.
REQ-007 cmd_operand  input  8  instruction operand.
REQ-008 alu_ac, alu_dr  output  8 each  ALU operand buses.
REQ-009 alu_mode  output  3  ALU mode select.
REQ-010 alu_activate  output  1  ALU trigger; the ALU computes on its rising edge.
REQ-011 alu_result  input  8  ALU result.
REQ-012 mem_wr_valid  output  1  store request.
REQ-013 mem_wr_data  output  8  store data.
REQ-014 mem_wr_ready  input  1  store accepted.
REQ-015 ac_out  output  8  architectural accumulator.
REQ-016 e_flag  output  1  carry/extend flag.
REQ-017 busy  output  1  high whenever the state is not IDLE.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 err  output  1  one-cycle pulse, coincident with done, on an illegal op or store timeout.

Function
REQ-020 The FSM SHALL have the states IDLE, SETUP, FIRE, CAPTURE and STORE.
REQ-021 cmd_ready SHALL equal (state==IDLE); a command is accepted on cycles where cmd_valid and cmd_ready are both high.
REQ-022 On accept, the block SHALL latch op and operand:
- ops 000-100 and 110 go to SETUP;
- op 101 goes to STORE;
- op 111 returns to IDLE with done=1 and err=1 on the next cycle, and AC is unchanged.
REQ-023 SETUP (1 cycle) SHALL drive alu_ac=AC, alu_dr=operand, alu_mode=op, alu_activate=0.
REQ-024 FIRE (1 cycle) SHALL hold the SETUP values with alu_activate=1.
REQ-025 CAPTURE (1 cycle) SHALL drive alu_activate=0, write alu_result into AC at the end of the cycle, then go to IDLE.
REQ-026 alu_ac, alu_dr and alu_mode SHALL be stable from SETUP through CAPTURE, and SHALL hold their last values in IDLE.
REQ-027 An ALU op SHALL take exactly 4 cycles from the accept edge to the done pulse; done is high in the first IDLE cycle after CAPTURE.
REQ-028 STORE SHALL drive mem_wr_valid=1 and mem_wr_data=AC, and SHALL hold both until mem_wr_ready=1.
- On ready: go to IDLE, done=1 next cycle, AC unchanged.
REQ-029 The STORE wait counter SHALL count cycles in STORE.
- If STORE_TIMEOUT cycles elapse without mem_wr_ready: drop mem_wr_valid, go to IDLE, done=1 and err=1.
- mem_wr_ready arriving in the same cycle as the timeout counts as success.
REQ-030 A back-to-back command offered during the done cycle SHALL be accepted, because cmd_ready is high in that cycle.
REQ-031 Commands offered while busy SHALL be ignored, not queued.
REQ-032 alu_activate SHALL come directly from a flop (glitch-free) and SHALL never be high for more than one cycle per command.

Reset
REQ-033 Asserting rst_n low SHALL immediately force:
- state=IDLE;
- AC=0, e_flag=0;
- alu_ac=0, alu_dr=0, alu_mode=000;
- alu_activate=0, mem_wr_valid=0, mem_wr_data=0;
- done=0, err=0, busy=0, timeout counter=0.
REQ-034 A reset during FIRE or STORE SHALL abort the command with no AC update and no done pulse.
REQ-035 The first command SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-036 With macro ALU_SEQ_CARRY_EN defined, e_flag SHALL update in CAPTURE:
- op 000: e_flag = bit 8 of the 9-bit sum AC+operand;
- op 001: e_flag = operand[7];
- all other ops leave e_flag unchanged.
REQ-037 Without ALU_SEQ_CARRY_EN, e_flag SHALL be constant 0 and the carry adder SHALL not be built.

Verification
REQ-038 Reset, then load 0xA5 (op 100) -> activate high exactly at accept+2, done at accept+4, ac_out=0xA5.
REQ-039 AC=0xF0, add 0x20 -> ac_out=0x10; e_flag=1 with ALU_SEQ_CARRY_EN, 0 without.
REQ-040 AC=0x3C, store with mem_wr_ready held low 3 cycles -> mem_wr_valid high 4 cycles, mem_wr_data=0x3C, done=1, err=0; then STORE_TIMEOUT=4 with ready never high -> valid drops after 4 cycles, done=1, err=1.
REQ-041 Op 111 with AC=0x55 -> done=1, err=1 at accept+1, ac_out=0x55, alu_activate never high.
REQ-042 rst_n pulsed low during FIRE of add -> activate=0 and AC=0 immediately, no done; cmd_valid held high while busy -> no second accept.
REQ-043 Back-to-back: load 0x05, then negate (op 110) offered in the done cycle -> second accept in that same cycle, ac_out=0xFB.
